// File: rtl/mini_rv_pkg.sv
// Shared decode definitions for the Mini-RISC-V pipeline: opcodes, immediate
// formats, the ID/EX control bundle and the immediate generator.
package mini_rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_INS = 32'h00000013;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_NONE} imm_type_e;

  // Control half of the ID/EX bundle; the XLEN/AW-wide data lives beside it in
  // decode_stage so the struct stays independent of the module parameters.
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       alu_src;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       link;
  } id_ex_t;

  function automatic logic [31:0] imm_gen(input logic [31:7] i, input imm_type_e t);
    case (t)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// 32 x XLEN register file, two combinational reads, one write; x0 reads zero.
// DECODE_WB_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            i_freeze,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [31:0][XLEN-1:0] r_regs;

  always_ff @(posedge clk) begin
    if (Rst)                                   r_regs <= '0;
    else if (i_we && i_wa != 5'd0 && !i_freeze) r_regs[i_wa] <= i_wd;
  end

`ifdef DECODE_WB_BYPASS_EN
  logic w_fwd1, w_fwd2;
  assign w_fwd1 = i_we && !i_freeze && (i_wa == i_ra1);
  assign w_fwd2 = i_we && !i_freeze && (i_wa == i_ra2);
  assign o_rd1  = (i_ra1 == 5'd0) ? '0 : w_fwd1 ? i_wd : r_regs[i_ra1];
  assign o_rd2  = (i_ra2 == 5'd0) ? '0 : w_fwd2 ? i_wd : r_regs[i_ra2];
`else
  assign o_rd1  = (i_ra1 == 5'd0) ? '0 : r_regs[i_ra1];
  assign o_rd2  = (i_ra2 == 5'd0) ? '0 : r_regs[i_ra2];
`endif

endmodule

// File: rtl/decode_stage.sv
// ID stage: register file, immediate/control decode, branch resolution, hazard
// stall and the ID/EX register. DECODE_WB_BYPASS_EN selects WB->ID forwarding.
module decode_stage
  import mini_rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 8
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            En,
  input  logic            debug,
  input  logic [AW-1:0]   IF_ID_pres_adr,
  input  logic [31:0]     ins,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            fetch_en,
  output logic            branch,
  output logic            IF_ID_jalr,
  output logic [AW-1:0]   branoff,
  output logic [AW-1:0]   ID_EX_pc,
  output logic [XLEN-1:0] ID_EX_rs1_data,
  output logic [XLEN-1:0] ID_EX_rs2_data,
  output logic [XLEN-1:0] ID_EX_imm,
  output logic [4:0]      ID_EX_rd,
  output logic [2:0]      ID_EX_funct3,
  output logic            ID_EX_funct7b5,
  output logic            ID_EX_alu_src,
  output logic            ID_EX_mem_rd,
  output logic            ID_EX_mem_wr,
  output logic            ID_EX_reg_wr,
  output logic            ID_EX_link
);

  logic [6:0]      w_op;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_rd1, w_rd2, w_imm;
  logic [AW-1:0]   w_rel, w_tgt;
  logic            w_valid, w_use1, w_use2, w_cond, w_run;
  logic            w_hit_ex, w_hit_wb, w_stall;
  imm_type_e       w_itype;
  id_ex_t          w_ctl, r_ctl;
  logic            r_flush_q;
  logic [AW-1:0]   r_pc;
  logic [XLEN-1:0] r_rs1, r_rs2, r_imm;

  // The wrong-path slot after a redirect decodes as an unsupported opcode.
  assign w_op  = r_flush_q ? 7'd0 : ins[6:0];
  assign w_rs1 = ins[19:15];
  assign w_rs2 = ins[24:20];
  assign w_rd  = ins[11:7];
  assign w_f3  = ins[14:12];

  regfile #(.XLEN(XLEN)) u_rf (
    .clk(clk), .Rst(Rst), .i_freeze(debug),
    .i_we(wb_en), .i_wa(wb_rd), .i_wd(wb_data),
    .i_ra1(w_rs1), .i_ra2(w_rs2), .o_rd1(w_rd1), .o_rd2(w_rd2)
  );

  always_comb begin
    w_ctl   = '0;
    w_valid = 1'b1;
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_itype = IMM_NONE;
    case (w_op)
      OP_R:      begin w_use1 = 1'b1; w_use2 = 1'b1; w_ctl.rd = w_rd; w_ctl.funct3 = w_f3;
                       w_ctl.funct7b5 = ins[30]; w_ctl.reg_wr = (w_rd != 5'd0); end
      OP_IMM:    begin w_use1 = 1'b1; w_itype = IMM_I; w_ctl.rd = w_rd; w_ctl.funct3 = w_f3;
                       w_ctl.funct7b5 = (w_f3 == 3'b101) && ins[30]; w_ctl.alu_src = 1'b1;
                       w_ctl.reg_wr = (w_rd != 5'd0); end
      OP_LOAD:   begin w_use1 = 1'b1; w_itype = IMM_I; w_ctl.rd = w_rd; w_ctl.funct3 = w_f3;
                       w_ctl.alu_src = 1'b1; w_ctl.mem_rd = 1'b1; w_ctl.reg_wr = (w_rd != 5'd0); end
      OP_STORE:  begin w_use1 = 1'b1; w_use2 = 1'b1; w_itype = IMM_S; w_ctl.funct3 = w_f3;
                       w_ctl.alu_src = 1'b1; w_ctl.mem_wr = 1'b1; end
      OP_BRANCH: begin w_use1 = 1'b1; w_use2 = 1'b1; w_itype = IMM_B; w_ctl.funct3 = w_f3; end
      OP_JAL:    begin w_itype = IMM_J; w_ctl.rd = w_rd; w_ctl.link = 1'b1;
                       w_ctl.reg_wr = (w_rd != 5'd0); end
      OP_JALR:   begin w_use1 = 1'b1; w_itype = IMM_I; w_ctl.rd = w_rd; w_ctl.funct3 = w_f3;
                       w_ctl.alu_src = 1'b1; w_ctl.link = 1'b1; w_ctl.reg_wr = (w_rd != 5'd0); end
      OP_LUI:    begin w_itype = IMM_U; w_ctl.rd = w_rd; w_ctl.alu_src = 1'b1;
                       w_ctl.reg_wr = (w_rd != 5'd0); end
      default:   w_valid = 1'b0;
    endcase
  end

  assign w_imm = XLEN'($signed(imm_gen(ins[31:7], w_itype)));

  always_comb begin
    case (w_f3)
      3'b000:  w_cond = (w_rd1 == w_rd2);
      3'b001:  w_cond = (w_rd1 != w_rd2);
      3'b100:  w_cond = ($signed(w_rd1) <  $signed(w_rd2));
      3'b101:  w_cond = ($signed(w_rd1) >= $signed(w_rd2));
      3'b110:  w_cond = (w_rd1 <  w_rd2);
      3'b111:  w_cond = (w_rd1 >= w_rd2);
      default: w_cond = 1'b0;
    endcase
  end

  // Hazards against the instruction in EX and, without bypass, the WB write.
  assign w_hit_ex = (r_ctl.rd != 5'd0) &&
                    ((w_use1 && w_rs1 == r_ctl.rd) || (w_use2 && w_rs2 == r_ctl.rd));
`ifdef DECODE_WB_BYPASS_EN
  assign w_hit_wb = 1'b0;
`else
  assign w_hit_wb = wb_en && (wb_rd != 5'd0) &&
                    ((w_use1 && w_rs1 == wb_rd) || (w_use2 && w_rs2 == wb_rd));
`endif
  assign w_stall = (r_ctl.mem_rd && w_hit_ex) ||
                   ((w_op == OP_BRANCH || w_op == OP_JALR) && r_ctl.reg_wr && w_hit_ex) ||
                   w_hit_wb;

  // Fetch already points at PC+4, so relative redirects carry imm-4.
  assign w_rel      = w_imm[AW-1:0] - AW'(4);
  assign w_tgt      = (w_rd1[AW-1:0] + w_imm[AW-1:0]) & ~AW'(1);
  assign w_run      = !Rst && !w_stall;
  assign branch     = w_run && ((w_op == OP_BRANCH && w_cond) || w_op == OP_JAL);
  assign IF_ID_jalr = w_run && (w_op == OP_JALR);
  assign branoff    = IF_ID_jalr ? w_tgt : branch ? w_rel : '0;
  assign fetch_en   = En && !debug && !w_stall;

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_flush_q <= 1'b0;
      r_ctl <= '0; r_pc <= '0; r_rs1 <= '0; r_rs2 <= '0; r_imm <= '0;
    end else if (En && !debug) begin
      r_flush_q <= branch || IF_ID_jalr;
      if (w_stall || !w_valid) begin
        r_ctl <= '0; r_pc <= '0; r_rs1 <= '0; r_rs2 <= '0; r_imm <= '0;
      end else begin
        r_ctl <= w_ctl;
        r_pc  <= IF_ID_pres_adr;
        r_rs1 <= w_use1 ? w_rd1 : '0;
        r_rs2 <= w_use2 ? w_rd2 : '0;
        r_imm <= w_imm;
      end
    end
  end

  assign ID_EX_pc       = r_pc;
  assign ID_EX_rs1_data = r_rs1;
  assign ID_EX_rs2_data = r_rs2;
  assign ID_EX_imm      = r_imm;
  assign ID_EX_rd       = r_ctl.rd;
  assign ID_EX_funct3   = r_ctl.funct3;
  assign ID_EX_funct7b5 = r_ctl.funct7b5;
  assign ID_EX_alu_src  = r_ctl.alu_src;
  assign ID_EX_mem_rd   = r_ctl.mem_rd;
  assign ID_EX_mem_wr   = r_ctl.mem_wr;
  assign ID_EX_reg_wr   = r_ctl.reg_wr;
  assign ID_EX_link     = r_ctl.link;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: branches, load-use, jalr, WB bypass/stall,
// debug freeze, stall-vs-redirect, x0 handling and reset during a stall.
module tb_decode_stage;
  import mini_rv_pkg::*;

  logic        clk = 1'b0;
  logic        Rst, En, debug, wb_en;
  logic [7:0]  IF_ID_pres_adr;
  logic [31:0] ins, wb_data;
  logic [4:0]  wb_rd;
  logic        fetch_en, branch, IF_ID_jalr;
  logic [7:0]  branoff, ID_EX_pc;
  logic [31:0] ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
  logic [4:0]  ID_EX_rd;
  logic [2:0]  ID_EX_funct3;
  logic        ID_EX_funct7b5, ID_EX_alu_src, ID_EX_mem_rd, ID_EX_mem_wr, ID_EX_reg_wr, ID_EX_link;
  int          n_chk = 0;
  int          n_err = 0;

  decode_stage #(.XLEN(32), .AW(8)) dut (
    .clk(clk), .Rst(Rst), .En(En), .debug(debug),
    .IF_ID_pres_adr(IF_ID_pres_adr), .ins(ins),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .fetch_en(fetch_en), .branch(branch), .IF_ID_jalr(IF_ID_jalr), .branoff(branoff),
    .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_rd(ID_EX_rd), .ID_EX_funct3(ID_EX_funct3),
    .ID_EX_funct7b5(ID_EX_funct7b5), .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_mem_rd(ID_EX_mem_rd),
    .ID_EX_mem_wr(ID_EX_mem_wr), .ID_EX_reg_wr(ID_EX_reg_wr), .ID_EX_link(ID_EX_link)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, OP_R};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  // All stimulus changes and checks happen 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    ins = NOP_INS; wb_en = 1'b1; wb_rd = rd; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; En = 1'b1; debug = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    IF_ID_pres_adr = 8'h00; ins = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
    step(); step();
    n_chk++; if (branch !== 1'b0) begin n_err++; $display("FAIL rst_branch got %0h want 0", branch); end
    n_chk++; if (branoff !== 8'h00) begin n_err++; $display("FAIL rst_branoff got %0h want 0", branoff); end
    n_chk++; if (ID_EX_pc !== 8'h00) begin n_err++; $display("FAIL rst_pc got %0h want 0", ID_EX_pc); end
    n_chk++; if ({ID_EX_alu_src, ID_EX_mem_rd, ID_EX_mem_wr, ID_EX_reg_wr, ID_EX_link} !== 5'b0)
      begin n_err++; $display("FAIL rst_ctl got %b want 00000", {ID_EX_alu_src, ID_EX_mem_rd, ID_EX_mem_wr, ID_EX_reg_wr, ID_EX_link}); end
    n_chk++; if (ID_EX_imm !== 32'd0) begin n_err++; $display("FAIL rst_imm got %0h want 0", ID_EX_imm); end
    Rst = 1'b0; ins = NOP_INS;
    step();
  endtask

  task automatic test_branch();
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd5);
    IF_ID_pres_adr = 8'h08; ins = enc_b(13'd16, 5'd2, 5'd1, 3'b000);
    #1;
    n_chk++; if (branch !== 1'b1) begin n_err++; $display("FAIL beq_branch got %0h want 1", branch); end
    n_chk++; if (branoff !== 8'h0C) begin n_err++; $display("FAIL beq_branoff got %0h want 0c", branoff); end
    n_chk++; if (fetch_en !== 1'b1) begin n_err++; $display("FAIL beq_fetch_en got %0h want 1", fetch_en); end
    step();
    n_chk++; if (ID_EX_pc !== 8'h08) begin n_err++; $display("FAIL beq_idex_pc got %0h want 08", ID_EX_pc); end
    IF_ID_pres_adr = 8'h0C; ins = enc_i(12'd7, 5'd0, 3'b000, 5'd5, OP_IMM);
    #1;
    n_chk++; if (branch !== 1'b0) begin n_err++; $display("FAIL flush_branch got %0h want 0", branch); end
    step();
    n_chk++; if ({ID_EX_reg_wr, ID_EX_alu_src, ID_EX_rd, ID_EX_pc} !== 15'd0)
      begin n_err++; $display("FAIL flush_bubble got %0h want 0", {ID_EX_reg_wr, ID_EX_alu_src, ID_EX_rd, ID_EX_pc}); end
    IF_ID_pres_adr = 8'h10; ins = enc_b(13'd16, 5'd2, 5'd1, 3'b001);
    #1;
    n_chk++; if (branch !== 1'b0) begin n_err++; $display("FAIL bne_nt got %0h want 0", branch); end
    step();
    wb_write(5'd10, 32'hFFFFFFFF);
    IF_ID_pres_adr = 8'h20; ins = enc_b(13'd8, 5'd1, 5'd10, 3'b100);
    #1;
    n_chk++; if (branch !== 1'b1) begin n_err++; $display("FAIL blt_signed got %0h want 1", branch); end
    n_chk++; if (branoff !== 8'h04) begin n_err++; $display("FAIL blt_branoff got %0h want 04", branoff); end
    step();
    ins = NOP_INS; step();
    ins = enc_b(13'd8, 5'd1, 5'd10, 3'b110);
    #1;
    n_chk++; if (branch !== 1'b0) begin n_err++; $display("FAIL bltu_nt got %0h want 0", branch); end
    step();
    IF_ID_pres_adr = 8'h30; ins = enc_b(-13'sd8, 5'd0, 5'd0, 3'b101);
    #1;
    n_chk++; if (branoff !== 8'hF4) begin n_err++; $display("FAIL bge_back_branoff got %0h want f4", branoff); end
    step();
    ins = NOP_INS; step();
  endtask

  task automatic test_load_use();
    IF_ID_pres_adr = 8'h40; ins = enc_i(12'd0, 5'd0, 3'b010, 5'd3, OP_LOAD);
    step();
    n_chk++; if (ID_EX_mem_rd !== 1'b1 || ID_EX_rd !== 5'd3) begin n_err++; $display("FAIL lw_issue got mem_rd=%0h rd=%0d want 1/3", ID_EX_mem_rd, ID_EX_rd); end
    IF_ID_pres_adr = 8'h44; ins = enc_r(5'd1, 5'd3, 5'd4);
    #1;
    n_chk++; if (fetch_en !== 1'b0) begin n_err++; $display("FAIL lu_stall got %0h want 0", fetch_en); end
    step();
    n_chk++; if (ID_EX_reg_wr !== 1'b0 || ID_EX_mem_rd !== 1'b0) begin n_err++; $display("FAIL lu_bubble got reg_wr=%0h mem_rd=%0h want 0/0", ID_EX_reg_wr, ID_EX_mem_rd); end
    n_chk++; if (fetch_en !== 1'b1) begin n_err++; $display("FAIL lu_release got %0h want 1", fetch_en); end
    step();
    n_chk++; if (ID_EX_rd !== 5'd4 || ID_EX_reg_wr !== 1'b1) begin n_err++; $display("FAIL lu_add got rd=%0d reg_wr=%0h want 4/1", ID_EX_rd, ID_EX_reg_wr); end
    n_chk++; if (ID_EX_rs2_data !== 32'd5) begin n_err++; $display("FAIL lu_add_rs2 got %0h want 5", ID_EX_rs2_data); end
    ins = NOP_INS; step();
  endtask

  task automatic test_jalr();
    wb_write(5'd5, 32'h00000101);
    IF_ID_pres_adr = 8'h50; ins = enc_i(12'd3, 5'd5, 3'b000, 5'd1, OP_JALR);
    #1;
    n_chk++; if (IF_ID_jalr !== 1'b1 || branch !== 1'b0) begin n_err++; $display("FAIL jalr_redir got jalr=%0h branch=%0h want 1/0", IF_ID_jalr, branch); end
    n_chk++; if (branoff !== 8'h04) begin n_err++; $display("FAIL jalr_branoff got %0h want 04", branoff); end
    step();
    n_chk++; if (ID_EX_link !== 1'b1 || ID_EX_rd !== 5'd1 || ID_EX_reg_wr !== 1'b1)
      begin n_err++; $display("FAIL jalr_idex got link=%0h rd=%0d reg_wr=%0h want 1/1/1", ID_EX_link, ID_EX_rd, ID_EX_reg_wr); end
    n_chk++; if (ID_EX_imm !== 32'd3) begin n_err++; $display("FAIL jalr_imm got %0h want 3", ID_EX_imm); end
    ins = enc_i(12'd1, 5'd0, 3'b000, 5'd9, OP_IMM); step();
    n_chk++; if (ID_EX_reg_wr !== 1'b0) begin n_err++; $display("FAIL jalr_flush got %0h want 0", ID_EX_reg_wr); end
    ins = NOP_INS; step();
  endtask

  task automatic test_wb_bypass();
    IF_ID_pres_adr = 8'h60; ins = enc_i(12'hFFF, 5'd7, 3'b000, 5'd8, OP_IMM);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
`ifdef DECODE_WB_BYPASS_EN
    #1;
    n_chk++; if (fetch_en !== 1'b1) begin n_err++; $display("FAIL byp_no_stall got %0h want 1", fetch_en); end
    step();
    wb_en = 1'b0;
`else
    #1;
    n_chk++; if (fetch_en !== 1'b0) begin n_err++; $display("FAIL wb_stall got %0h want 0", fetch_en); end
    step();
    wb_en = 1'b0;
    n_chk++; if (ID_EX_reg_wr !== 1'b0) begin n_err++; $display("FAIL wb_bubble got %0h want 0", ID_EX_reg_wr); end
    #1;
    n_chk++; if (fetch_en !== 1'b1) begin n_err++; $display("FAIL wb_release got %0h want 1", fetch_en); end
    step();
`endif
    n_chk++; if (ID_EX_rs1_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wb_rs1 got %0h want deadbeef", ID_EX_rs1_data); end
    n_chk++; if (ID_EX_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL wb_imm got %0h want ffffffff", ID_EX_imm); end
    n_chk++; if (ID_EX_rd !== 5'd8) begin n_err++; $display("FAIL wb_rd got %0d want 8", ID_EX_rd); end
    ins = NOP_INS; step();
  endtask

  task automatic test_debug_freeze();
    IF_ID_pres_adr = 8'h70; ins = enc_i(12'd0, 5'd0, 3'b010, 5'd3, OP_LOAD);
    step();
    IF_ID_pres_adr = 8'h74; ins = enc_r(5'd1, 5'd3, 5'd4);
    debug = 1'b1; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (fetch_en !== 1'b0) begin n_err++; $display("FAIL dbg_fetch_en[%0d] got %0h want 0", i, fetch_en); end
      n_chk++; if (ID_EX_mem_rd !== 1'b1 || ID_EX_pc !== 8'h70) begin n_err++; $display("FAIL dbg_frozen[%0d] got mem_rd=%0h pc=%0h want 1/70", i, ID_EX_mem_rd, ID_EX_pc); end
    end
    debug = 1'b0; wb_en = 1'b0;
    #1;
    n_chk++; if (fetch_en !== 1'b0) begin n_err++; $display("FAIL dbg_resume_stall got %0h want 0", fetch_en); end
    step(); step();
    n_chk++; if (ID_EX_rd !== 5'd4 || ID_EX_pc !== 8'h74) begin n_err++; $display("FAIL dbg_add got rd=%0d pc=%0h want 4/74", ID_EX_rd, ID_EX_pc); end
    n_chk++; if (ID_EX_rs2_data !== 32'd5) begin n_err++; $display("FAIL dbg_wb_dropped got %0h want 5", ID_EX_rs2_data); end
    ins = NOP_INS; step();
  endtask

  task automatic test_stall_vs_redirect();
    IF_ID_pres_adr = 8'h80; ins = enc_i(12'd3, 5'd0, 3'b000, 5'd15, OP_IMM);
    step();
    IF_ID_pres_adr = 8'h84; ins = enc_b(13'd8, 5'd0, 5'd15, 3'b000);
    #1;
    n_chk++; if (fetch_en !== 1'b0 || branch !== 1'b0 || branoff !== 8'h00)
      begin n_err++; $display("FAIL svr_stall got fe=%0h br=%0h off=%0h want 0/0/0", fetch_en, branch, branoff); end
    step();
    n_chk++; if (branch !== 1'b1 || branoff !== 8'h04) begin n_err++; $display("FAIL svr_reeval got br=%0h off=%0h want 1/04", branch, branoff); end
    step();
    ins = NOP_INS; step();
  endtask

  task automatic test_x0();
    IF_ID_pres_adr = 8'h90; ins = enc_r(5'd0, 5'd0, 5'd13);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    #1;
    n_chk++; if (fetch_en !== 1'b1) begin n_err++; $display("FAIL x0_no_stall got %0h want 1", fetch_en); end
    step();
    wb_en = 1'b0;
    step();
    n_chk++; if (ID_EX_rs1_data !== 32'd0 || ID_EX_rs2_data !== 32'd0)
      begin n_err++; $display("FAIL x0_read got %0h/%0h want 0/0", ID_EX_rs1_data, ID_EX_rs2_data); end
    IF_ID_pres_adr = 8'hA0; ins = enc_j(21'd8, 5'd0);
    #1;
    n_chk++; if (branch !== 1'b1 || branoff !== 8'h04) begin n_err++; $display("FAIL jal_redir got br=%0h off=%0h want 1/04", branch, branoff); end
    step();
    n_chk++; if (ID_EX_link !== 1'b1 || ID_EX_reg_wr !== 1'b0) begin n_err++; $display("FAIL jal_x0 got link=%0h reg_wr=%0h want 1/0", ID_EX_link, ID_EX_reg_wr); end
    ins = NOP_INS; step();
    ins = 32'hFFFFFFFF; step();
    n_chk++; if ({ID_EX_alu_src, ID_EX_reg_wr, ID_EX_rd, ID_EX_pc} !== 15'd0)
      begin n_err++; $display("FAIL bad_op_bubble got %0h want 0", {ID_EX_alu_src, ID_EX_reg_wr, ID_EX_rd, ID_EX_pc}); end
    ins = NOP_INS; step();
  endtask

  task automatic test_reset_mid_stall();
    IF_ID_pres_adr = 8'hB0; ins = enc_i(12'd0, 5'd0, 3'b010, 5'd3, OP_LOAD);
    step();
    IF_ID_pres_adr = 8'hB4; ins = enc_r(5'd1, 5'd3, 5'd4);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    n_chk++; if (ID_EX_mem_rd !== 1'b0 || ID_EX_rd !== 5'd0) begin n_err++; $display("FAIL rms_cleared got mem_rd=%0h rd=%0d want 0/0", ID_EX_mem_rd, ID_EX_rd); end
    ins = enc_b(13'd8, 5'd0, 5'd1, 3'b000);
    #1;
    n_chk++; if (fetch_en !== 1'b1) begin n_err++; $display("FAIL rms_fetch_en got %0h want 1", fetch_en); end
    n_chk++; if (branch !== 1'b1) begin n_err++; $display("FAIL rms_x1_cleared got %0h want 1", branch); end
    step();
    ins = NOP_INS; step();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_load_use();
    test_jalr();
    test_wb_bypass();
    test_debug_freeze();
    test_stall_vs_redirect();
    test_x0();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the Mini-RISC-V pipeline (IF, ID, EX, WB). It sits directly downstream of fetch and takes in the fetched instruction and its PC. It holds the 32x32 register file, generates immediates and control, and resolves branches and jumps. It drives the redirect and stall signals back to fetch and registers the ID/EX pipeline bundle for execute.

## Interface
Parameters:
- `XLEN`, 32: register and datapath width.
- `AW`, 8: instruction address width, matching fetch's byte PC.

Ports:
- `clk`  in  1  clock
- `Rst`  in  1  reset, synchronous, active-high
- `En`  in  1  global pipeline enable
- `debug`  in  1  freezes all state when high
- `IF_ID_pres_adr`  in  AW  PC of `ins`
- `ins`  in  32  instruction word from fetch
- `wb_en`, `wb_rd`, `wb_data`  in  1/5/XLEN  register-file write port from WB
- `fetch_en`  out  1  enable to fetch; low stalls fetch and instruction memory
- `branch`  out  1  relative redirect to fetch
- `IF_ID_jalr`  out  1  absolute redirect to fetch
- `branoff`  out  AW  redirect offset or target
- `ID_EX_pc`  out  AW  PC of the issued instruction
- `ID_EX_rs1_data`, `ID_EX_rs2_data`, `ID_EX_imm`  out  XLEN  source operands and immediate
- `ID_EX_rd`, `ID_EX_funct3`  out  5/3  destination register and funct3
- `ID_EX_funct7b5`, `ID_EX_alu_src`, `ID_EX_mem_rd`, `ID_EX_mem_wr`, `ID_EX_reg_wr`, `ID_EX_link`  out  1 each  control

## Operation
- Supported opcodes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI. Any other opcode, including 0, decodes as a bubble with all control 0.
- Immediates are sign-extended to XLEN (I/S/B/J/U formats). Register x0 reads as 0, and writes to x0 are discarded.
- Branch compare is done in ID on forwarded operands for all six funct3 conditions.
- Fetch's PC is already at decode PC+4, so:
  - Taken B-type or JAL: `branch`=1, `branoff` = (imm − 4)[AW-1:0], modulo 2^AW.
  - JALR: `IF_ID_jalr`=1, `branoff` = ((rs1 + imm) & ~1)[AW-1:0].
- Flush: a redirect sets `flush_q`. On the next enabled cycle the incoming `ins` is treated as a bubble and `flush_q` clears. This gives one wrong-path squash per redirect.
- Hazard `stall`, which drops `fetch_en`:
  - Case (a): `ID_EX_mem_rd` is set and `ID_EX_rd` (nonzero) matches rs1 or rs2 of the current instruction (load-use).
  - Case (b): the current instruction is BRANCH or JALR and `ID_EX_reg_wr` is set with a matching nonzero `ID_EX_rd`.
- During a stall:
  - A bubble is written into ID/EX.
  - The redirect outputs are forced to 0.
  - `ins` holds, because instruction memory is disabled.
- JAL/JALR set `ID_EX_link`=1 and `ID_EX_reg_wr`=(rd≠0). Execute writes PC+4.
- `fetch_en` = `En` & !`debug` & !`stall`.

## Timing
- ID/EX registers update on the clk edge when `En` & !`debug`, and hold otherwise. `flush_q` follows the same rule.
- Register file write happens on the clk edge when `wb_en` & (`wb_rd`≠0), with no enable gating except `debug`. Reads are combinational.
- `branch`, `IF_ID_jalr` and `branoff` are combinational in the same cycle the instruction sits in ID, and are sampled by fetch on that edge.
- Reset:
  - All ID/EX outputs are 0 (a bubble).
  - `flush_q`=0; `branch`, `IF_ID_jalr` and `branoff` are 0.
  - All 32 registers are cleared.
- Reset mid-stall clears everything, and the first post-reset cycle issues no redirect.
- Stall and redirect in the same cycle: the stall wins and the redirect is re-evaluated once the stall clears.
- Redirect while `flush_q`=1 cannot occur, because the flushed slot is a bubble.

## Configuration
- `DECODE_WB_BYPASS_EN` defined: a same-cycle WB write to rs1/rs2 is forwarded to the read data (write-first).
- Not defined: reads return the old value. The hazard unit adds case (c) `wb_en` & `wb_rd`≠0 & `wb_rd` matches a source, which stalls one cycle.

## Structure
- Package `mini_rv_pkg`: opcode localparams, `imm_type_e` enum (I/S/B/J/U/NONE), `id_ex_t` packed struct for the ID/EX bundle, and `NOP_INS` = 32'h00000013.
- One sub-module `regfile` (2R1W, x0 hardwired zero, macro-controlled bypass). Immediate generation, control decode, hazard logic and pipeline registers stay in `decode_stage`.

## Test plan
- Reset, then write x1=5 and x2=5 via the WB port; decode `beq x1,x2,+16` at PC 0x08 -> `branch`=1, `branoff`=0x0C; next cycle ID/EX is a bubble.
- `lw x3,0(x0)` followed by `add x4,x3,x1` -> one cycle with `fetch_en`=0 and a bubble in ID/EX, then the add issues with rd=4.
- Set x5=0x00000101; decode `jalr x1,3(x5)` -> `IF_ID_jalr`=1, `branoff`=0x04, `ID_EX_link`=1, `ID_EX_rd`=1.
- WB writes x7=0xDEADBEEF in the same cycle `addi x8,x7,-1` decodes -> with the macro, `ID_EX_rs1_data`=0xDEADBEEF and `ID_EX_imm`=0xFFFFFFFF; without it, one stall cycle, then the same values.
- `debug`=1 for 3 cycles during a load-use stall -> all outputs are frozen and `fetch_en`=0; resume matches the undisturbed run.
- Write to x0 with 0x1234 -> x0 still reads 0, and `ID_EX_reg_wr`=0 for `jal x0`.
